// File: rtl/imem_port_arbiter.sv
// Single-port instruction BRAM arbiter: IF fetch vs. program loader, with read-return routing.
// Optional boot hold (loader-only until load_done) is enabled by defining IMEM_ARB_BOOT_HOLD_EN.
module imem_port_arbiter #(
  parameter int          ADDR_W       = 13,
  parameter int          STARVE_LIMIT = 8,
  parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [31:0]       fetch_rdata,
  output logic              fetch_err,
  input  logic              load_req,
  input  logic              load_we,
  input  logic [31:0]       load_addr,
  input  logic [31:0]       load_wdata,
  output logic              load_gnt,
  output logic              load_rvalid,
  output logic [31:0]       load_rdata,
  input  logic              load_done,
  output logic              core_hold,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_din,
  input  logic [31:0]       bram_dout
);

  localparam int               CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD} owner_e;

  logic             boot;
  logic             fetch_in_range, fetch_aligned, load_in_range;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  owner_e           rd_owner, rd_owner_nxt;
  logic             fetch_err_q, fetch_oor_q, load_oor_q;
  logic [1:0]       unused_load_lsb;

  assign fetch_in_range  = (fetch_addr[31:ADDR_W+2] == '0);
  assign fetch_aligned   = (fetch_addr[1:0] == 2'b00);
  assign load_in_range   = (load_addr[31:ADDR_W+2] == '0);
  assign unused_load_lsb = load_addr[1:0];

`ifdef IMEM_ARB_BOOT_HOLD_EN
  typedef enum logic {ST_RUN, ST_BOOT} state_e;
  state_e state, state_nxt;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_BOOT && load_done) state_nxt = ST_RUN;
  end

  assign boot = (state == ST_BOOT);
`else
  logic unused_load_done;
  assign unused_load_done = load_done;
  assign boot             = 1'b0;
`endif

  // Grants are combinational but forced low while rst is high so every output is 0 in reset.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves one
    // unassigned would infer a latch.
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    core_hold = 1'b0;
    if (!rst) begin
      if (boot) begin
        load_gnt  = load_req;
        core_hold = 1'b1;
      end else begin
        fetch_gnt = fetch_req && !(load_req && starve_cnt == LIMIT);
        load_gnt  = load_req && !fetch_gnt;
        core_hold = fetch_req && !fetch_gnt;
      end
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (boot || !load_req || load_gnt) starve_nxt = '0;
    else if (starve_cnt < LIMIT)       starve_nxt = starve_cnt + 1'b1;
  end

  always_comb begin
    rd_owner_nxt = OWN_NONE;
    if (fetch_gnt)                 rd_owner_nxt = OWN_FETCH;
    else if (load_gnt && !load_we) rd_owner_nxt = OWN_LOAD;
  end

  assign bram_en = (fetch_gnt && fetch_in_range) || (load_gnt && load_in_range);
  assign bram_we = load_gnt && load_we && load_in_range;
  assign bram_din = load_gnt ? load_wdata : 32'h0;
  assign bram_addr = fetch_gnt ? fetch_addr[ADDR_W+1:2] :
                     load_gnt  ? load_addr[ADDR_W+1:2]  : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt  <= '0;
      rd_owner    <= OWN_NONE;
      fetch_err_q <= 1'b0;
      fetch_oor_q <= 1'b0;
      load_oor_q  <= 1'b0;
    end else begin
      starve_cnt  <= starve_nxt;
      rd_owner    <= rd_owner_nxt;
      fetch_err_q <= !fetch_in_range || !fetch_aligned;
      fetch_oor_q <= !fetch_in_range;
      load_oor_q  <= !load_in_range;
    end
  end

  // Out-of-range reads never enabled the BRAM, so their data is substituted here.
  assign fetch_rvalid = (rd_owner == OWN_FETCH);
  assign fetch_err    = fetch_rvalid && fetch_err_q;
  assign fetch_rdata  = !fetch_rvalid ? 32'h0 : (fetch_oor_q ? NOP_INSTR : bram_dout);
  assign load_rvalid  = (rd_owner == OWN_LOAD);
  assign load_rdata   = (load_rvalid && !load_oor_q) ? bram_dout : 32'h0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: vector table plus starvation, async-reset and boot-hold sequences.
module tb_imem_port_arbiter;

  logic        clk, rst;
  logic        fetch_req, fetch_gnt, fetch_rvalid, fetch_err;
  logic [31:0] fetch_addr, fetch_rdata;
  logic        load_req, load_we, load_gnt, load_rvalid, load_done;
  logic [31:0] load_addr, load_wdata, load_rdata;
  logic        core_hold, bram_en, bram_we;
  logic [12:0] bram_addr;
  logic [31:0] bram_din, bram_dout;

  int n_checks = 0;
  int n_pass   = 0;

  imem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
    .load_req(load_req), .load_we(load_we), .load_addr(load_addr), .load_wdata(load_wdata),
    .load_gnt(load_gnt), .load_rvalid(load_rvalid), .load_rdata(load_rdata),
    .load_done(load_done), .core_hold(core_hold),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: unwritten word i reads back as i.
  bit [31:0] mem     [0:8191];
  bit        written [0:8191];
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) begin
        mem[bram_addr]     <= bram_din;
        written[bram_addr] <= 1'b1;
      end else begin
        bram_dout <= written[bram_addr] ? mem[bram_addr] : {19'h0, bram_addr};
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic fr, input logic [31:0] fa, input logic lr, input logic lw,
                       input logic [31:0] la, input logic [31:0] ld, input logic dn);
    @(negedge clk);
    fetch_req = fr; fetch_addr = fa;
    load_req = lr; load_we = lw; load_addr = la; load_wdata = ld; load_done = dn;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".fetch_gnt"},    {31'h0, fetch_gnt},    32'h0);
    check({tag, ".load_gnt"},     {31'h0, load_gnt},     32'h0);
    check({tag, ".core_hold"},    {31'h0, core_hold},    32'h0);
    check({tag, ".bram_en"},      {31'h0, bram_en},      32'h0);
    check({tag, ".bram_we"},      {31'h0, bram_we},      32'h0);
    check({tag, ".fetch_rvalid"}, {31'h0, fetch_rvalid}, 32'h0);
    check({tag, ".load_rvalid"},  {31'h0, load_rvalid},  32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch_req = 1'b1; fetch_addr = 32'h0;
    load_req = 1'b1; load_we = 1'b1; load_addr = 32'h0; load_wdata = 32'hFFFF_FFFF; load_done = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; fetch_req = 1'b0; load_req = 1'b0; load_we = 1'b0; load_wdata = 32'h0;
`ifdef IMEM_ARB_BOOT_HOLD_EN
    load_done = 1'b1;
    @(negedge clk);
    load_done = 1'b0;
`endif
  endtask

  typedef struct packed {
    logic        fr;   logic [31:0] fa;
    logic        lr;   logic        lw;  logic [31:0] la;  logic [31:0] ld;  logic dn;
    logic        e_fg; logic        e_lg; logic e_hold; logic e_en; logic e_we;
    logic [12:0] e_addr; logic [31:0] e_din;
    logic        e_frv; logic [31:0] e_frd; logic e_ferr;
    logic        e_lrv; logic [31:0] e_lrd;
  } vec_t;

  vec_t vecs [16];

  initial begin
    // Return columns (e_frv..e_lrd) describe the read granted in the previous row.
    vecs[0]  = '{1'b1, 32'h0,     1'b0, 1'b0, 32'h0,     32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 13'h0,    32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h4,     1'b0, 1'b0, 32'h0,     32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 13'h1,    32'h0,        1'b1, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 32'h8,     1'b0, 1'b0, 32'h0,     32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 13'h2,    32'h0,        1'b1, 32'h1,        1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0,     1'b1, 1'b1, 32'h40,    32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 13'h10,   32'hDEADBEEF, 1'b1, 32'h2,        1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 32'h40,    1'b0, 1'b0, 32'h0,     32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 13'h10,   32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'h8000,  1'b0, 1'b0, 32'h0,     32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0,    32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'h6,     1'b0, 1'b0, 32'h0,     32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 13'h1,    32'h0,        1'b1, 32'h13,       1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0,     1'b1, 1'b0, 32'h40,    32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 13'h10,   32'h0,        1'b1, 32'h1,        1'b1, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h0,     1'b1, 1'b0, 32'h10000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0,    32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[9]  = '{1'b0, 32'h0,     1'b1, 1'b1, 32'h20000, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0,    32'h12345678, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 32'h0,     1'b0, 1'b0, 32'h0,     32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0,    32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 32'h7FFC,  1'b0, 1'b0, 32'h0,     32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 13'h1FFF, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 32'h0,     1'b0, 1'b0, 32'h0,     32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0,    32'h0,        1'b1, 32'h1FFF,     1'b0, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 32'hC,     1'b1, 1'b0, 32'h8,     32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 13'h3,    32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 32'h0,     1'b1, 1'b0, 32'h8,     32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 13'h2,    32'h0,        1'b1, 32'h3,        1'b0, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 32'h0,     1'b0, 1'b0, 32'h0,     32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0,    32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h2};

    do_reset();

    for (int i = 0; i < 16; i++) begin
      vec_t v;
      v = vecs[i];
      drive(v.fr, v.fa, v.lr, v.lw, v.la, v.ld, v.dn);
      check($sformatf("v%0d.fetch_gnt", i),    {31'h0, fetch_gnt},    {31'h0, v.e_fg});
      check($sformatf("v%0d.load_gnt", i),     {31'h0, load_gnt},     {31'h0, v.e_lg});
      check($sformatf("v%0d.core_hold", i),    {31'h0, core_hold},    {31'h0, v.e_hold});
      check($sformatf("v%0d.bram_en", i),      {31'h0, bram_en},      {31'h0, v.e_en});
      check($sformatf("v%0d.bram_we", i),      {31'h0, bram_we},      {31'h0, v.e_we});
      check($sformatf("v%0d.bram_addr", i),    {19'h0, bram_addr},    {19'h0, v.e_addr});
      check($sformatf("v%0d.bram_din", i),     bram_din,              v.e_din);
      check($sformatf("v%0d.fetch_rvalid", i), {31'h0, fetch_rvalid}, {31'h0, v.e_frv});
      check($sformatf("v%0d.load_rvalid", i),  {31'h0, load_rvalid},  {31'h0, v.e_lrv});
      if (v.e_frv) begin
        check($sformatf("v%0d.fetch_rdata", i), fetch_rdata,         v.e_frd);
        check($sformatf("v%0d.fetch_err", i),   {31'h0, fetch_err},  {31'h0, v.e_ferr});
      end
      if (v.e_lrv) check($sformatf("v%0d.load_rdata", i), load_rdata, v.e_lrd);
    end

    // Starvation: both request every cycle; every 9th cycle the loader is forced a slot.
    begin
      logic prev_f, prev_l;
      int   prev_c;
      prev_f = 1'b0; prev_l = 1'b0; prev_c = 0;
      for (int c = 0; c < 19; c++) begin
        logic exp_l;
        if (c < 18) drive(1'b1, 32'h400 + 32'(4 * c), 1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
        else        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        exp_l = (c < 18) && (c % 9 == 8);
        if (c < 18) begin
          check($sformatf("starve%0d.fetch_gnt", c), {31'h0, fetch_gnt}, {31'h0, !exp_l});
          check($sformatf("starve%0d.load_gnt", c),  {31'h0, load_gnt},  {31'h0, exp_l});
          check($sformatf("starve%0d.core_hold", c), {31'h0, core_hold}, {31'h0, exp_l});
        end
        check($sformatf("starve%0d.fetch_rvalid", c), {31'h0, fetch_rvalid}, {31'h0, prev_f});
        check($sformatf("starve%0d.load_rvalid", c),  {31'h0, load_rvalid},  {31'h0, prev_l});
        if (prev_f) check($sformatf("starve%0d.fetch_rdata", c), fetch_rdata, 32'(256 + prev_c));
        if (prev_l) check($sformatf("starve%0d.load_rdata", c),  load_rdata,  32'd64);
        prev_f = (c < 18) && !exp_l;
        prev_l = exp_l;
        prev_c = c;
      end
    end

    // Async reset right after a fetch grant: outputs drop at once, the read never returns.
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("midrst.grant", {31'h0, fetch_gnt}, 32'h1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    fetch_req = 1'b0;
    @(negedge clk);
    #1;
    check("midrst.no_rvalid", {31'h0, fetch_rvalid}, 32'h0);

`ifdef IMEM_ARB_BOOT_HOLD_EN
    // Still in BOOT after that reset: fetch held off while the loader writes words 0..3.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0, 1'b1, 1'b1, 32'(4 * i), 32'hA0 + 32'(i), (i == 3) ? 1'b1 : 1'b0);
      check($sformatf("boot%0d.fetch_gnt", i), {31'h0, fetch_gnt}, 32'h0);
      check($sformatf("boot%0d.core_hold", i), {31'h0, core_hold}, 32'h1);
      check($sformatf("boot%0d.load_gnt", i),  {31'h0, load_gnt},  32'h1);
      check($sformatf("boot%0d.bram_we", i),   {31'h0, bram_we},   32'h1);
    end
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("boot.run_fetch_gnt", {31'h0, fetch_gnt}, 32'h1);
    check("boot.run_core_hold", {31'h0, core_hold}, 32'h0);
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("boot.first_rvalid", {31'h0, fetch_rvalid}, 32'h1);
    check("boot.first_rdata",  fetch_rdata,           32'hA0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("boot.second_rdata", fetch_rdata,           32'hA1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
